imem_fetch_ctrl: RTL and testbench
==================================

# imem_fetch_ctrl

Instruction-memory request sequencer between the fetch stage and the i-mem port. It turns fetch-stage address requests into a held-until-granted memory request handshake. It tracks in-flight reads in order and drops responses made stale by a pipeline flush. Surviving instruction words are buffered in a small FIFO that the fetch stage drains.

## Interface
- ADDR_WIDTH, 32, fetch/memory address width
- DATA_WIDTH, 32, instruction word width (XLEN_WIDTH)
- MAX_OUTSTANDING, 2, max granted-but-unanswered reads (≥1)
- FIFO_DEPTH, 2, response buffer entries (≥1)

- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous, active-low reset
- fetch_req  input  1  fetch stage wants a word at fetch_addr
- fetch_addr  input  ADDR_WIDTH  requested address (pc_reg)
- fetch_accept  output  1  one-cycle pulse: fetch_addr latched, fetch stage may advance PC
- fetch_flush  input  1  discard all in-flight and buffered fetches (PC_flush)
- fetch_valid  output  1  fetch_data/fetch_rsp_addr valid
- fetch_data  output  DATA_WIDTH  instruction word
- fetch_rsp_addr  output  ADDR_WIDTH  address of fetch_data
- fetch_ready  input  1  consumer takes head entry when fetch_valid=1
- mem_req  output  1  memory read request
- mem_addr  output  ADDR_WIDTH  read address, stable while mem_req=1
- mem_gnt  input  1  request accepted this cycle
- mem_rvalid  input  1  read data returned, in grant order
- mem_rdata  input  DATA_WIDTH  read data
- busy  output  1  state REQ, or any outstanding entry, or FIFO non-empty

## Operation
- FSM: IDLE, REQ. Reset → IDLE.
- Credit = (outstanding < MAX_OUTSTANDING) and (live_outstanding + fifo_count + (state==REQ & !kill) < FIFO_DEPTH). live_outstanding = outstanding entries with stale bit clear. This guarantees no FIFO overflow; mem_rvalid is never back-pressured.
- IDLE: fetch_req & credit & !fetch_flush → latch fetch_addr into req_addr, pulse fetch_accept, clear kill, go REQ.
- REQ: mem_req=1, mem_addr=req_addr. No abort: request held until mem_gnt.
  - On mem_gnt, push {req_addr, stale=kill} into the outstanding queue.
  - If fetch_req & credit (counting this grant) & !fetch_flush in the same cycle, latch the new address, pulse fetch_accept and stay REQ. Otherwise go IDLE.
- fetch_flush (any state): set stale on every outstanding entry, including one pushed this cycle. Set kill if staying in REQ. Clear FIFO. No fetch_accept that cycle.
- mem_rvalid: pop outstanding queue head. If head stale or fetch_flush this cycle → drop. Else push {head addr, mem_rdata} into FIFO.
- FIFO pop when fetch_valid & fetch_ready & !fetch_flush. Simultaneous push and pop legal at full.
- mem_rvalid with empty outstanding queue: protocol error, ignored (no state change).
- Counters: outstanding width $clog2(MAX_OUTSTANDING+1), fifo_count width $clog2(FIFO_DEPTH+1). Pointers wrap modulo depth; depth need not be power of 2.

## Timing
- Reset values: mem_req=0, mem_addr=0, fetch_accept=0, fetch_valid=0, fetch_data=0, fetch_rsp_addr=0, busy=0. Queues empty, kill=0.
- fetch_accept is combinational in the decision cycle. mem_req rises the following cycle.
- Back-to-back: one grant per cycle sustained while mem_gnt=1 and credit available.
- mem_rvalid at cycle r → fetch_valid at r+1 (registered FIFO, no bypass).
- Flush at cycle f: fetch_valid=0 from f+1. Every response to a request granted ≤ f, or pending in REQ at f, is dropped.
- Reset asserted mid-operation clears everything immediately. The memory is reset in the same domain, so it returns no late responses.

## Test plan
- Single fetch: fetch_req, addr 0x0000_0100, mem_gnt after 2 cycles, rvalid 3 cycles later with 0x0000_0013 → one fetch_accept, mem_addr=0x100 stable 3 cycles, fetch_valid one cycle after rvalid with data 0x13, addr 0x100.
- Streaming: fetch_req held, addrs 0x100/0x104/0x108, mem_gnt=1, rvalid 1 cycle after grant, fetch_ready=1 → one grant per cycle, in-order outputs, no drops.
- Back-pressure: fetch_ready=0, defaults → exactly 2 grants, then mem_req stays 0 until a pop. Then one new grant.
- Flush with 2 in flight: grant 0x200, 0x204, flush, then request 0x300 → both old rvalids dropped. Only 0x300 data appears on fetch_valid.
- Flush while REQ awaiting gnt (addr 0x400) → mem_req held to gnt, response dropped. Flush same cycle as rvalid → that word dropped.
- Async reset mid-stream → all outputs 0 immediately, before the next clock edge. The first post-reset fetch behaves as the single-fetch scenario.

Source files
------------

// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundles between fetch stage, fetch controller and instruction memory.
// Handshakes: fetch_accept/mem_gnt complete a request only in the cycle they are high; fetch_valid/fetch_ready move a word only when both are high.
interface imem_fetch_bus_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  fetch_req;
   logic [ADDR_WIDTH-1:0] fetch_addr;
   logic                  fetch_accept;
   logic                  fetch_flush;
   logic                  fetch_valid;
   logic [DATA_WIDTH-1:0] fetch_data;
   logic [ADDR_WIDTH-1:0] fetch_rsp_addr;
   logic                  fetch_ready;

   modport master (
      output fetch_req, fetch_addr, fetch_flush, fetch_ready,
      input  fetch_accept, fetch_valid, fetch_data, fetch_rsp_addr
   );

   modport slave (
      input  fetch_req, fetch_addr, fetch_flush, fetch_ready,
      output fetch_accept, fetch_valid, fetch_data, fetch_rsp_addr
   );
endinterface

interface imem_mem_bus_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  mem_req;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic                  mem_gnt;
   logic                  mem_rvalid;
   logic [DATA_WIDTH-1:0] mem_rdata;

   modport master (
      output mem_req, mem_addr,
      input  mem_gnt, mem_rvalid, mem_rdata
   );

   modport slave (
      input  mem_req, mem_addr,
      output mem_gnt, mem_rvalid, mem_rdata
   );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-memory request sequencer: held request to i-mem, in-order
// outstanding tracking with flush-stale marking, and a small response FIFO.
module imem_fetch_ctrl #(
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 2,
   parameter int FIFO_DEPTH      = 2
) (
   input  logic                 clk,
   input  logic                 reset_n,
   imem_fetch_bus_if.slave      fetch,
   imem_mem_bus_if.master       mem,
   output logic                 busy,
   output logic [0:0]           dbg_state
);

   localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
   localparam int FCW = $clog2(FIFO_DEPTH + 1);
   localparam int OPW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int FPW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int SW  = OCW + FCW + 1;

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_REQ  = 1'b1;

   logic [0:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_req_addr;
   logic                  r_kill;

   logic [ADDR_WIDTH-1:0]  r_oq_addr [MAX_OUTSTANDING];
   logic [MAX_OUTSTANDING-1:0] r_oq_stale;
   logic [OPW-1:0]         r_oq_wr;
   logic [OPW-1:0]         r_oq_rd;
   logic [OCW-1:0]         r_oq_cnt;
   logic [OCW-1:0]         r_live_cnt;

   logic [ADDR_WIDTH-1:0]  r_ff_addr [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0]  r_ff_data [FIFO_DEPTH];
   logic [FPW-1:0]         r_ff_wr;
   logic [FPW-1:0]         r_ff_rd;
   logic [FCW-1:0]         r_ff_cnt;

   logic                   w_in_req;
   logic                   w_gnt;
   logic                   w_oq_pop;
   logic                   w_head_stale;
   logic                   w_ff_push;
   logic                   w_ff_pop;
   logic                   w_ff_valid;
   logic [SW-1:0]          w_oq_eff;
   logic [SW-1:0]          w_slots;
   logic                   w_credit;
   logic                   w_can_take;
   logic                   w_accept;
   logic [MAX_OUTSTANDING-1:0] w_oq_stale_nxt;

   function automatic logic [OPW-1:0] oq_inc(input logic [OPW-1:0] p);
      return (p == OPW'(MAX_OUTSTANDING - 1)) ? '0 : p + OPW'(1);
   endfunction

   function automatic logic [FPW-1:0] ff_inc(input logic [FPW-1:0] p);
      return (p == FPW'(FIFO_DEPTH - 1)) ? '0 : p + FPW'(1);
   endfunction

   assign w_in_req     = (r_state == S_REQ);
   assign w_gnt        = w_in_req & mem.mem_gnt;
   assign w_oq_pop     = mem.mem_rvalid & (r_oq_cnt != '0);
   assign w_head_stale = r_oq_stale[r_oq_rd];
   assign w_ff_push    = w_oq_pop & ~w_head_stale & ~fetch.fetch_flush;
   assign w_ff_valid   = (r_ff_cnt != '0);
   assign w_ff_pop     = w_ff_valid & fetch.fetch_ready & ~fetch.fetch_flush;

   // Every accepted, non-killed fetch reserves a FIFO slot until it is popped
   // or dropped, so responses can never find the FIFO full.
   assign w_oq_eff   = SW'(r_oq_cnt) + SW'(w_gnt);
   assign w_slots    = SW'(r_live_cnt) + SW'(r_ff_cnt) + SW'(w_in_req & ~r_kill);
   assign w_credit   = (w_oq_eff < SW'(MAX_OUTSTANDING)) && (w_slots < SW'(FIFO_DEPTH));
   assign w_can_take = (r_state == S_IDLE) | w_gnt;
   assign w_accept   = reset_n & fetch.fetch_req & ~fetch.fetch_flush & w_credit & w_can_take;

   always_comb begin
      w_oq_stale_nxt = r_oq_stale;
      if (fetch.fetch_flush) w_oq_stale_nxt = '1;
      if (w_gnt) w_oq_stale_nxt[r_oq_wr] = r_kill | fetch.fetch_flush;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= S_IDLE;
         r_req_addr <= '0;
         r_kill     <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE:  if (w_accept) r_state <= S_REQ;
            S_REQ:   if (w_gnt && !w_accept) r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
         if (w_accept) r_req_addr <= fetch.fetch_addr;
         if (w_accept) r_kill <= 1'b0;
         else if (w_gnt) r_kill <= 1'b0;
         else if (fetch.fetch_flush && w_in_req) r_kill <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_oq_stale <= '0;
         r_oq_wr    <= '0;
         r_oq_rd    <= '0;
         r_oq_cnt   <= '0;
         r_live_cnt <= '0;
      end else begin
         r_oq_stale <= w_oq_stale_nxt;
         if (w_gnt) r_oq_wr <= oq_inc(r_oq_wr);
         if (w_oq_pop) r_oq_rd <= oq_inc(r_oq_rd);
         r_oq_cnt <= r_oq_cnt + OCW'(w_gnt) - OCW'(w_oq_pop);
         if (fetch.fetch_flush) r_live_cnt <= '0;
         else r_live_cnt <= r_live_cnt + OCW'(w_gnt & ~r_kill) - OCW'(w_oq_pop & ~w_head_stale);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ff_wr  <= '0;
         r_ff_rd  <= '0;
         r_ff_cnt <= '0;
      end else if (fetch.fetch_flush) begin
         r_ff_wr  <= '0;
         r_ff_rd  <= '0;
         r_ff_cnt <= '0;
      end else begin
         if (w_ff_push) r_ff_wr <= ff_inc(r_ff_wr);
         if (w_ff_pop) r_ff_rd <= ff_inc(r_ff_rd);
         r_ff_cnt <= r_ff_cnt + FCW'(w_ff_push) - FCW'(w_ff_pop);
      end
   end

   // Payload storage needs no reset: outputs are gated by the valid counts.
   always_ff @(posedge clk) begin
      if (w_gnt) r_oq_addr[r_oq_wr] <= r_req_addr;
      if (w_ff_push) begin
         r_ff_addr[r_ff_wr] <= r_oq_addr[r_oq_rd];
         r_ff_data[r_ff_wr] <= mem.mem_rdata;
      end
   end

   assign mem.mem_req          = w_in_req;
   assign mem.mem_addr         = r_req_addr;
   assign fetch.fetch_accept   = w_accept;
   assign fetch.fetch_valid    = w_ff_valid;
   assign fetch.fetch_data     = w_ff_valid ? r_ff_data[r_ff_rd] : '0;
   assign fetch.fetch_rsp_addr = w_ff_valid ? r_ff_addr[r_ff_rd] : '0;
   assign busy                 = w_in_req | (r_oq_cnt != '0) | w_ff_valid;
   assign dbg_state            = r_state;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: cycle-by-cycle stimulus with
// hand-computed expectations for handshake, flush, back-pressure and reset.
module tb_imem_fetch_ctrl;

   logic       clk;
   logic       reset_n;
   logic       busy;
   logic [0:0] dbg_state;

   int n_checks = 0;
   int n_err    = 0;
   logic [63:0] exp_q[$];

   imem_fetch_bus_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) f_if ();
   imem_mem_bus_if   #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m_if ();

   imem_fetch_ctrl #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTSTANDING(2), .FIFO_DEPTH(2)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .fetch     (f_if),
      .mem       (m_if),
      .busy      (busy),
      .dbg_state (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #4;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_word(input string tag);
      logic [63:0] e;
      e = (exp_q.size() != 0) ? exp_q[0] : '1;
      chk({tag, "_valid"}, f_if.fetch_valid, 1);
      chk({tag, "_addr"}, f_if.fetch_rsp_addr, e[63:32]);
      chk({tag, "_data"}, f_if.fetch_data, e[31:0]);
      if (f_if.fetch_ready && exp_q.size() != 0) e = exp_q.pop_front();
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_mem_req"}, m_if.mem_req, 0);
      chk({tag, "_mem_addr"}, m_if.mem_addr, 0);
      chk({tag, "_accept"}, f_if.fetch_accept, 0);
      chk({tag, "_valid"}, f_if.fetch_valid, 0);
      chk({tag, "_data"}, f_if.fetch_data, 0);
      chk({tag, "_rsp_addr"}, f_if.fetch_rsp_addr, 0);
      chk({tag, "_busy"}, busy, 0);
   endtask

   // Grant two cycles after mem_req rises, response three cycles after grant.
   task automatic single_fetch(input string tag);
      f_if.fetch_req = 1'b1; f_if.fetch_addr = 32'h100; settle();
      chk({tag, "_accept"}, f_if.fetch_accept, 1);
      chk({tag, "_req_t0"}, m_if.mem_req, 0);
      step(); f_if.fetch_req = 1'b0; settle();
      chk({tag, "_req_t1"}, m_if.mem_req, 1);
      chk({tag, "_addr_t1"}, m_if.mem_addr, 32'h100);
      chk({tag, "_noacc_t1"}, f_if.fetch_accept, 0);
      step(); settle();
      chk({tag, "_req_t2"}, m_if.mem_req, 1);
      chk({tag, "_addr_t2"}, m_if.mem_addr, 32'h100);
      step(); m_if.mem_gnt = 1'b1; settle();
      chk({tag, "_req_t3"}, m_if.mem_req, 1);
      chk({tag, "_addr_t3"}, m_if.mem_addr, 32'h100);
      step(); m_if.mem_gnt = 1'b0; settle();
      chk({tag, "_req_t4"}, m_if.mem_req, 0);
      chk({tag, "_busy_t4"}, busy, 1);
      step(); settle();
      step(); m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'h13;
      exp_q.push_back({32'h100, 32'h13}); settle();
      chk({tag, "_novalid_t6"}, f_if.fetch_valid, 0);
      step(); m_if.mem_rvalid = 1'b0; f_if.fetch_ready = 1'b1; settle();
      check_word({tag, "_word"});
      step(); f_if.fetch_ready = 1'b0; settle();
      chk({tag, "_empty"}, f_if.fetch_valid, 0);
      chk({tag, "_idle"}, busy, 0);
   endtask

   initial begin
      reset_n = 1'b0;
      f_if.fetch_req = 1'b0; f_if.fetch_addr = '0; f_if.fetch_flush = 1'b0; f_if.fetch_ready = 1'b0;
      m_if.mem_gnt = 1'b0; m_if.mem_rvalid = 1'b0; m_if.mem_rdata = '0;
      #3;
      check_all_zero("reset");
      @(posedge clk); @(posedge clk); #1;
      reset_n = 1'b1;

      // Response with nothing outstanding is ignored
      m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'hBAD; settle();
      step(); m_if.mem_rvalid = 1'b0; settle();
      chk("stray_valid", f_if.fetch_valid, 0);
      chk("stray_busy", busy, 0);
      step();

      single_fetch("single");

      // Streaming with fetch_ready held
      step(); f_if.fetch_ready = 1'b1; f_if.fetch_req = 1'b1; f_if.fetch_addr = 32'h100; settle();
      chk("s0_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_addr = 32'h104; m_if.mem_gnt = 1'b1; settle();
      chk("s1_addr", m_if.mem_addr, 32'h100);
      chk("s1_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_addr = 32'h108; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'hAAA1;
      exp_q.push_back({32'h100, 32'hAAA1}); settle();
      chk("s2_req", m_if.mem_req, 1);
      chk("s2_addr", m_if.mem_addr, 32'h104);
      chk("s2_nocredit", f_if.fetch_accept, 0);
      step(); m_if.mem_gnt = 1'b0; m_if.mem_rdata = 32'hAAA2;
      exp_q.push_back({32'h104, 32'hAAA2}); settle();
      chk("s3_req", m_if.mem_req, 0);
      chk("s3_nocredit", f_if.fetch_accept, 0);
      check_word("s3_w0");
      step(); m_if.mem_rvalid = 1'b0; settle();
      check_word("s4_w1");
      chk("s4_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_req = 1'b0; m_if.mem_gnt = 1'b1; settle();
      chk("s5_req", m_if.mem_req, 1);
      chk("s5_addr", m_if.mem_addr, 32'h108);
      chk("s5_empty", f_if.fetch_valid, 0);
      step(); m_if.mem_gnt = 1'b0; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'hAAA3;
      exp_q.push_back({32'h108, 32'hAAA3}); settle();
      chk("s6_req", m_if.mem_req, 0);
      step(); m_if.mem_rvalid = 1'b0; settle();
      check_word("s7_w2");
      step(); f_if.fetch_ready = 1'b0; settle();
      chk("s8_empty", f_if.fetch_valid, 0);
      chk("s8_idle", busy, 0);

      // Back-pressure: consumer stalled, FIFO fills, requests stop
      step(); f_if.fetch_req = 1'b1; f_if.fetch_addr = 32'h500; settle();
      chk("b0_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_addr = 32'h504; m_if.mem_gnt = 1'b1; settle();
      chk("b1_addr", m_if.mem_addr, 32'h500);
      chk("b1_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_addr = 32'h508; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'hB0;
      exp_q.push_back({32'h500, 32'hB0}); settle();
      chk("b2_addr", m_if.mem_addr, 32'h504);
      chk("b2_nocredit", f_if.fetch_accept, 0);
      step(); m_if.mem_gnt = 1'b0; m_if.mem_rdata = 32'hB1;
      exp_q.push_back({32'h504, 32'hB1}); settle();
      chk("b3_req", m_if.mem_req, 0);
      chk("b3_nocredit", f_if.fetch_accept, 0);
      step(); m_if.mem_rvalid = 1'b0; settle();
      chk("b4_nocredit", f_if.fetch_accept, 0);
      chk("b4_req", m_if.mem_req, 0);
      chk("b4_valid", f_if.fetch_valid, 1);
      step(); settle();
      chk("b5_nocredit", f_if.fetch_accept, 0);
      chk("b5_req", m_if.mem_req, 0);
      step(); f_if.fetch_ready = 1'b1; settle();
      check_word("b6_w0");
      chk("b6_nocredit", f_if.fetch_accept, 0);
      step(); f_if.fetch_ready = 1'b0; settle();
      check_word("b7_w1");
      chk("b7_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_req = 1'b0; m_if.mem_gnt = 1'b1; settle();
      chk("b8_req", m_if.mem_req, 1);
      chk("b8_addr", m_if.mem_addr, 32'h508);
      step(); m_if.mem_gnt = 1'b0; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'hB2;
      exp_q.push_back({32'h508, 32'hB2}); settle();
      chk("b9_req", m_if.mem_req, 0);
      step(); m_if.mem_rvalid = 1'b0; f_if.fetch_ready = 1'b1; settle();
      check_word("b10_w1");
      step(); settle();
      check_word("b11_w2");
      step(); f_if.fetch_ready = 1'b0; settle();
      chk("b12_empty", f_if.fetch_valid, 0);
      chk("b12_idle", busy, 0);

      // Flush with two reads in flight
      step(); f_if.fetch_ready = 1'b1; f_if.fetch_req = 1'b1; f_if.fetch_addr = 32'h200; settle();
      chk("f0_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_addr = 32'h204; m_if.mem_gnt = 1'b1; settle();
      chk("f1_addr", m_if.mem_addr, 32'h200);
      chk("f1_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_req = 1'b0; settle();
      chk("f2_addr", m_if.mem_addr, 32'h204);
      step(); m_if.mem_gnt = 1'b0; f_if.fetch_flush = 1'b1; f_if.fetch_req = 1'b1;
      f_if.fetch_addr = 32'h300; settle();
      chk("f3_noaccept", f_if.fetch_accept, 0);
      chk("f3_busy", busy, 1);
      step(); f_if.fetch_flush = 1'b0; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'hDEAD0; settle();
      chk("f4_nocredit", f_if.fetch_accept, 0);
      step(); m_if.mem_rdata = 32'hDEAD1; settle();
      chk("f5_accept", f_if.fetch_accept, 1);
      chk("f5_dropped", f_if.fetch_valid, 0);
      step(); m_if.mem_rvalid = 1'b0; f_if.fetch_req = 1'b0; m_if.mem_gnt = 1'b1; settle();
      chk("f6_req", m_if.mem_req, 1);
      chk("f6_addr", m_if.mem_addr, 32'h300);
      chk("f6_dropped", f_if.fetch_valid, 0);
      step(); m_if.mem_gnt = 1'b0; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'h3333;
      exp_q.push_back({32'h300, 32'h3333}); settle();
      chk("f7_empty", f_if.fetch_valid, 0);
      step(); m_if.mem_rvalid = 1'b0; settle();
      check_word("f8_w");
      step(); f_if.fetch_ready = 1'b0; settle();
      chk("f9_empty", f_if.fetch_valid, 0);
      chk("f9_idle", busy, 0);

      // Flush while the request waits for its grant
      step(); f_if.fetch_req = 1'b1; f_if.fetch_addr = 32'h400; settle();
      chk("g0_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_req = 1'b0; f_if.fetch_flush = 1'b1; settle();
      chk("g1_req", m_if.mem_req, 1);
      chk("g1_addr", m_if.mem_addr, 32'h400);
      step(); f_if.fetch_flush = 1'b0; settle();
      chk("g2_req_held", m_if.mem_req, 1);
      chk("g2_addr", m_if.mem_addr, 32'h400);
      step(); m_if.mem_gnt = 1'b1; settle();
      chk("g3_req", m_if.mem_req, 1);
      step(); m_if.mem_gnt = 1'b0; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'h4444; settle();
      chk("g4_req", m_if.mem_req, 0);
      chk("g4_busy", busy, 1);
      step(); m_if.mem_rvalid = 1'b0; settle();
      chk("g5_dropped", f_if.fetch_valid, 0);
      chk("g5_idle", busy, 0);

      // Flush clears a buffered word and drops a same-cycle response
      step(); f_if.fetch_req = 1'b1; f_if.fetch_addr = 32'h600; settle();
      chk("h0_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_addr = 32'h604; m_if.mem_gnt = 1'b1; settle();
      chk("h1_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_req = 1'b0; m_if.mem_rvalid = 1'b1; m_if.mem_rdata = 32'h6660; settle();
      chk("h2_addr", m_if.mem_addr, 32'h604);
      step(); m_if.mem_gnt = 1'b0; m_if.mem_rdata = 32'h6661; f_if.fetch_flush = 1'b1; settle();
      chk("h3_valid", f_if.fetch_valid, 1);
      chk("h3_data", f_if.fetch_data, 32'h6660);
      step(); m_if.mem_rvalid = 1'b0; f_if.fetch_flush = 1'b0; settle();
      chk("h4_cleared", f_if.fetch_valid, 0);
      chk("h4_idle", busy, 0);

      // Asynchronous reset in the middle of traffic
      step(); f_if.fetch_req = 1'b1; f_if.fetch_addr = 32'h700; settle();
      chk("r0_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_addr = 32'h704; m_if.mem_gnt = 1'b1; settle();
      chk("r1_accept", f_if.fetch_accept, 1);
      step(); f_if.fetch_req = 1'b0; m_if.mem_gnt = 1'b0; m_if.mem_rvalid = 1'b1;
      m_if.mem_rdata = 32'h7770; settle();
      chk("r2_req", m_if.mem_req, 1);
      chk("r2_addr", m_if.mem_addr, 32'h704);
      step(); m_if.mem_rvalid = 1'b0; settle();
      chk("r3_valid", f_if.fetch_valid, 1);
      chk("r3_data", f_if.fetch_data, 32'h7770);
      #1 reset_n = 1'b0;
      #1;
      check_all_zero("midreset");
      step(); reset_n = 1'b1;
      single_fetch("post_reset");

      chk("scoreboard_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
